scan_sel_gen: RTL and testbench

- Upstream select sequencer for the 3-to-8 decoder stage. It drives the decoder's 3-bit select (i) and enable (en) to scan a programmable channel window.
- Each channel is held enabled for a programmable dwell time, followed by a one-cycle break-before-make gap.
- Supports continuous or single-pass scanning, with start/stop control and status pulses.

---
 rtl/scan_sel_gen.sv | 122 ++++++++++++
 tb/tb_scan_sel_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sel_gen.sv
// Select sequencer for the 3-to-8 decoder: scans a channel window with a
// programmable dwell and a one-cycle break-before-make gap per channel.
module scan_sel_gen #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [2:0]         first,
   input  logic [2:0]         last,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         i,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DWELL,
      S_GAP
   } state_t;

   localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

   state_t             r_state;
   logic [2:0]         r_i;
   logic [2:0]         r_first;
   logic [2:0]         r_last;
   logic               r_mode;
   logic               r_en;
   logic               r_busy;
   logic               r_done;
   logic               r_wrap;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_cnt;

   logic [DWELL_W-1:0] w_dwell_eff;
   logic               w_at_last;

   // A requested dwell of zero still gives one enabled cycle
   assign w_dwell_eff = (dwell == '0) ? ONE : dwell;
   assign w_at_last   = (r_i == r_last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_i     <= 3'd0;
         r_first <= 3'd0;
         r_last  <= 3'd0;
         r_mode  <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
         r_dwell <= ONE;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         r_wrap <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  r_first <= first;
                  r_last  <= last;
                  r_mode  <= mode;
                  r_dwell <= w_dwell_eff;
                  r_i     <= first;
                  r_cnt   <= w_dwell_eff - ONE;
                  r_en    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_DWELL;
               end
            end
            S_DWELL: begin
               if (stop) begin
                  r_en    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  r_en    <= 1'b0;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end
            S_GAP: begin
               if (stop) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_at_last && r_mode) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  // i only moves here, while en is low
                  r_i     <= w_at_last ? r_first : r_i + 3'd1;
                  r_wrap  <= w_at_last;
                  r_cnt   <= r_dwell - ONE;
                  r_en    <= 1'b1;
                  r_state <= S_DWELL;
               end
            end
            default: begin
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign i    = r_i;
   assign en   = r_en;
   assign busy = r_busy;
   assign done = r_done;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: scenario table plus hand-written corner cases,
// expected cycle traces queued at stimulus time and compared each cycle.
module tb_scan_sel_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [2:0] first = 3'd0;
   logic [2:0] last = 3'd0;
   logic [7:0] dwell = 8'd0;
   logic [2:0] i;
   logic       en;
   logic       busy;
   logic       done;
   logic       wrap;

   scan_sel_gen #(.DWELL_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .first (first),
      .last  (last),
      .dwell (dwell),
      .i     (i),
      .en    (en),
      .busy  (busy),
      .done  (done),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] i;
      logic       en;
      logic       busy;
      logic       done;
      logic       wrap;
   } out_t;

   typedef struct {
      logic [2:0] f;
      logic [2:0] l;
      int         dw;
      bit         md;
      int         maxc;
      bit         do_stop;
   } scen_t;

   out_t       exp_q[$];
   logic [2:0] exp_last_i = 3'd0;
   int         errors = 0;
   int         checks = 0;
   string      tag = "init";

   task automatic push(input logic [2:0] ei, input bit een, input bit eb,
                       input bit ed, input bit ew);
      out_t e;
      e = {ei, een, eb, ed, ew};
      exp_q.push_back(e);
      exp_last_i = ei;
   endtask

   task automatic tick();
      out_t a;
      out_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = {i, en, busy, done, wrap};
         checks++;
         if (a !== e)
            begin
               errors++;
               $display("FAIL %s t=%0t: got i=%0d en=%0b busy=%0b done=%0b wrap=%0b exp i=%0d en=%0b busy=%0b done=%0b wrap=%0b",
                        tag, $time, a.i, a.en, a.busy, a.done, a.wrap,
                        e.i, e.en, e.busy, e.done, e.wrap);
            end
      end
   endtask

   // Expected trace of a scan, built from the channel list rather than states
   task automatic gen(input logic [2:0] f, input logic [2:0] l, input int dw,
                      input bit md, input int maxc, output int n);
      int         d;
      logic [2:0] ch;
      bit         wr;
      d  = (dw == 0) ? 1 : dw;
      ch = f;
      wr = 1'b0;
      n  = 0;
      while (n < maxc) begin
         for (int k = 0; k < d && n < maxc; k++) begin
            push(ch, 1, 1, 0, (k == 0) && wr);
            n++;
         end
         if (n < maxc) begin
            push(ch, 0, 1, 0, 0);
            n++;
         end
         wr = 1'b0;
         if (ch == l) begin
            if (md) begin
               if (n < maxc) begin push(ch, 0, 0, 1, 0); n++; end
               if (n < maxc) begin push(ch, 0, 0, 0, 0); n++; end
               break;
            end
            ch = f;
            wr = 1'b1;
         end else begin
            ch = ch + 3'd1;
         end
      end
   endtask

   task automatic launch(input logic [2:0] f, input logic [2:0] l,
                         input int dw, input bit md, input int maxc,
                         output int n);
      first = f;
      last  = l;
      dwell = 8'(dw);
      mode  = md;
      start = 1'b1;
      gen(f, l, dw, md, maxc, n);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         if (k == 0) start = 1'b0;
      end
   endtask

   task automatic do_stop();
      stop = 1'b1;
      push(exp_last_i, 0, 0, 0, 0);
      tick();
      stop = 1'b0;
   endtask

   // Break-before-make: i must not move across an edge where en was high
   logic [2:0] p_i;
   logic       p_en;
   logic       p_rst;
   bit         p_ok = 1'b0;
   always @(negedge clk) begin
      if (p_ok && p_en && p_rst) begin
         checks++;
         if (i !== p_i) begin
            errors++;
            $display("FAIL bbm t=%0t: got i=%0d after en=1 at i=%0d exp i=%0d",
                     $time, i, p_i, p_i);
         end
      end
      p_i   = i;
      p_en  = en;
      p_rst = rst_n;
      p_ok  = 1'b1;
   end

   scen_t tbl[6];
   int    n;

   initial begin
      tbl[0] = '{3'd2, 3'd4, 3, 1'b1, 1000, 1'b0};
      tbl[1] = '{3'd6, 3'd1, 1, 1'b0, 20,   1'b1};
      tbl[2] = '{3'd5, 3'd5, 0, 1'b1, 1000, 1'b0};
      tbl[3] = '{3'd7, 3'd0, 2, 1'b1, 1000, 1'b0};
      tbl[4] = '{3'd0, 3'd7, 1, 1'b0, 21,   1'b1};
      tbl[5] = '{3'd3, 3'd3, 4, 1'b0, 13,   1'b1};

      tag   = "reset";
      rst_n = 1'b0;
      start = 1'b1;
      first = 3'd3;
      dwell = 8'd2;
      push(0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0);
      tick();
      tick();
      start = 1'b0;
      rst_n = 1'b1;
      tag   = "post_reset_idle";
      push(0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0);
      tick();
      tick();

      for (int s = 0; s < 6; s++) begin
         tag = $sformatf("scen%0d", s);
         launch(tbl[s].f, tbl[s].l, tbl[s].dw, tbl[s].md, tbl[s].maxc, n);
         run(n);
         if (tbl[s].do_stop) do_stop();
      end

      tag   = "start_stop_idle";
      start = 1'b1;
      stop  = 1'b1;
      push(exp_last_i, 0, 0, 0, 0);
      push(exp_last_i, 0, 0, 0, 0);
      tick();
      tick();
      start = 1'b0;
      stop  = 1'b0;

      tag = "stop_mid_dwell";
      launch(3'd2, 3'd5, 10, 1'b0, 4, n);
      run(n);
      do_stop();
      push(exp_last_i, 0, 0, 0, 0);
      tick();
      tag = "restart_full_dwell";
      launch(3'd2, 3'd2, 10, 1'b1, 1000, n);
      run(n);

      tag = "start_while_busy";
      launch(3'd1, 3'd2, 2, 1'b1, 1000, n);
      for (int k = 0; k < n; k++) begin
         tick();
         if (k == 0) start = 1'b0;
         if (k == 1) begin
            start = 1'b1;
            first = 3'd5;
            last  = 3'd0;
            dwell = 8'd9;
            mode  = 1'b0;
         end
         if (k == 2) start = 1'b0;
      end

      tag = "reset_mid_scan";
      launch(3'd4, 3'd6, 3, 1'b1, 3, n);
      run(n);
      rst_n = 1'b0;
      push(0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      push(0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0);
      tick();
      tick();

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d unchecked entries exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
